led_share_arb: RTL

LED_SHARE_ARB -- requirements
Module: led_share_arb

---
 rtl/led_arb_pkg.sv | 37 +++
 rtl/ms_tick_gen.sv | 29 ++
 rtl/led_share_arb.sv | 135 +++++++++++++
 3 files changed

// File: rtl/led_arb_pkg.sv
// rtl/led_arb_pkg.sv - shared types and helpers for the LED bank arbiter
package led_arb_pkg;

    localparam int N_REQ = 3;
    localparam int LED_W = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN    = 2'd1,
        SWITCH = 2'd2
    } state_t;

    typedef logic [1:0] owner_t;

    // First requester above 'last' (wrapping modulo N_REQ); returns 'last'
    // itself only when it is the sole requester.
    function automatic owner_t rr_pick(input owner_t last, input logic [N_REQ-1:0] r);
        owner_t pick;
        owner_t cand;
        logic   found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = owner_t'((int'(last) + i) % N_REQ);
            if (!found && r[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [N_REQ-1:0] owner_onehot(input owner_t o);
        return N_REQ'(1) << o;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - free-running millisecond tick generator
//
// Ports:
//   sys_clk   - system clock
//   sys_rst_n - asynchronous active-low reset
//   tick      - one-cycle pulse while the counter sits at CNT_MAX
module ms_tick_gen #(
    parameter logic [25:0] CNT_MAX = 26'd49_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    output logic tick
);

    logic [25:0] cnt;

    assign tick = (cnt == CNT_MAX);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= 26'd0;
        end else if (tick) begin
            cnt <= 26'd0;
        end else begin
            cnt <= cnt + 26'd1;
        end
    end

endmodule

// File: rtl/led_share_arb.sv
// rtl/led_share_arb.sv - round-robin arbiter sharing one LED bank among three requesters
//
// Ports:
//   sys_clk, sys_rst_n      - clock, asynchronous active-low reset
//   req[2:0]                - level-sensitive bank requests
//   req_led0/1/2[6:0]       - pattern offered by each requester
//   grant[2:0]              - one-hot current owner (zero when none)
//   led[6:0]                - registered bank drive
//   busy                    - high in OWN or SWITCH
//
// Build option: LED_ARB_PRIO_EN makes requester 0 high priority (preempts
// other owners and wins every re-arbitration out of SWITCH).
module led_share_arb
    import led_arb_pkg::*;
#(
    parameter logic [25:0] CNT_MAX = 26'd49_999,
    parameter logic [6:0]  HOLD_MS = 7'd10
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [LED_W-1:0] req_led0,
    input  logic [LED_W-1:0] req_led1,
    input  logic [LED_W-1:0] req_led2,
    output logic [N_REQ-1:0] grant,
    output logic [LED_W-1:0] led,
    output logic             busy
);

    state_t     state, state_nxt;
    owner_t     owner, owner_nxt;
    owner_t     last_owner, last_nxt;
    logic [6:0] hold_cnt, hold_nxt;
    logic       tick;

    logic [N_REQ-1:0] owner_oh;
    logic             owner_req;
    logic             others_req;
    logic             expired;
    logic             preempt;
    owner_t           winner;
    owner_t           winner_sw;
    logic [LED_W-1:0] owner_led;

    ms_tick_gen #(
        .CNT_MAX (CNT_MAX)
    ) u_tick (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .tick      (tick)
    );

    assign owner_oh   = owner_onehot(owner);
    assign owner_req  = |(req & owner_oh);
    assign others_req = |(req & ~owner_oh);
    assign expired    = (hold_cnt == HOLD_MS);
    // last_owner already holds the outgoing owner while in SWITCH, so a
    // single round-robin search serves both IDLE and SWITCH.
    assign winner     = rr_pick(last_owner, req);

`ifdef LED_ARB_PRIO_EN
    assign preempt    = req[0] && (owner != 2'd0);
    assign winner_sw  = req[0] ? 2'd0 : winner;
`else
    assign preempt    = 1'b0;
    assign winner_sw  = winner;
`endif

    always_comb begin
        owner_led = '0;
        case (owner)
            2'd0:    owner_led = req_led0;
            2'd1:    owner_led = req_led1;
            2'd2:    owner_led = req_led2;
            default: owner_led = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last_owner;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = OWN;
                    owner_nxt = winner;
                    hold_nxt  = 7'd0;
                end
            end
            OWN: begin
                if (tick && (hold_cnt < HOLD_MS)) begin
                    hold_nxt = hold_cnt + 7'd1;
                end
                if (!owner_req || preempt || (expired && others_req)) begin
                    state_nxt = SWITCH;
                    last_nxt  = owner;
                end
            end
            SWITCH: begin
                if (|req) begin
                    state_nxt = OWN;
                    owner_nxt = winner_sw;
                    hold_nxt  = 7'd0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            owner      <= 2'd0;
            last_owner <= 2'd2;
            hold_cnt   <= 7'd0;
            led        <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_nxt;
            hold_cnt   <= hold_nxt;
            led        <= (state == OWN) ? owner_led : '0;
        end
    end

    assign grant = (state == OWN) ? owner_oh : '0;
    assign busy  = (state != IDLE);

endmodule
